// File: rtl/ovi_load_packer.sv
// rtl/ovi_load_packer.sv - packs per-element vector load responses into load lines
// with seq_id tagging and a closing sync_end per memop.
module ovi_load_packer #(
    parameter int MEMDATA_W = 512,
    parameter int SBID_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SBID_W-1:0]    start_sb_id,
    input  logic [1:0]           start_sew,
    input  logic [11:0]          start_vl,
    input  logic [4:0]           start_vreg,
    input  logic                 kill,
    input  logic                 rsp_valid,
    input  logic [31:0]          rsp_data,
    output logic                 mem_ready,
    output logic                 busy,
    output logic                 load_valid,
    output logic [MEMDATA_W-1:0] load_data,
    output logic [SBID_W-1:0]    seq_sb_id,
    output logic [6:0]           seq_el_count,
    output logic [5:0]           seq_el_off,
    output logic [10:0]          seq_el_id,
    output logic [4:0]           seq_v_reg,
    output logic [63:0]          load_mask,
    output logic                 load_mask_valid,
    output logic                 sync_end,
    output logic [SBID_W-1:0]    sync_sb_id,
    output logic [14:0]          vstart_vlfof
);

    // SLOT_W must hold the 8-bit elements-per-line count itself, not just EPL-1.
    localparam int SLOT_W = $clog2(MEMDATA_W / 8) + 1;
    localparam int SH_W   = $clog2(MEMDATA_W);

    typedef enum logic [1:0] {IDLE, LOAD, EMIT, SYNC} state_t;

    state_t               r_state;
    logic [SBID_W-1:0]    r_sb_id;
    logic [1:0]           r_sew;
    logic [11:0]          r_vl;
    logic [4:0]           r_vreg;
    logic [11:0]          r_idx;
    logic [SLOT_W-1:0]    r_slot;
    logic [10:0]          r_line_first;
    logic [4:0]           r_line_num;
    logic [MEMDATA_W-1:0] r_buf;

    logic [SLOT_W-1:0]    w_epl;
    logic [31:0]          w_elem;
    logic [SH_W-1:0]      w_shift;
    logic [SLOT_W-1:0]    w_slot_nx;
    logic [11:0]          w_idx_nx;
    logic                 w_accept;
    logic                 w_line_done;
    logic                 w_emit;
    logic                 w_sync;

    always_comb begin
        w_epl   = SLOT_W'(MEMDATA_W / 32);
        w_elem  = rsp_data;
        w_shift = SH_W'(r_slot) << 5;
        case (r_sew)
            2'd0: begin
                w_epl   = SLOT_W'(MEMDATA_W / 8);
                w_elem  = {24'd0, rsp_data[7:0]};
                w_shift = SH_W'(r_slot) << 3;
            end
            2'd1: begin
                w_epl   = SLOT_W'(MEMDATA_W / 16);
                w_elem  = {16'd0, rsp_data[15:0]};
                w_shift = SH_W'(r_slot) << 4;
            end
            default: ;
        endcase
    end

    assign w_accept    = (r_state == LOAD) && rsp_valid && !kill;
    assign w_slot_nx   = r_slot + SLOT_W'(1);
    assign w_idx_nx    = r_idx + 12'd1;
    assign w_line_done = w_accept && ((w_slot_nx == w_epl) || (w_idx_nx == r_vl));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_sb_id      <= '0;
            r_sew        <= '0;
            r_vl         <= '0;
            r_vreg       <= '0;
            r_idx        <= '0;
            r_slot       <= '0;
            r_line_first <= '0;
            r_line_num   <= '0;
            r_buf        <= '0;
        end else if (r_state == IDLE) begin
            if (start && (start_sew != 2'd3)) begin
                r_sb_id      <= start_sb_id;
                r_sew        <= start_sew;
                r_vl         <= start_vl;
                r_vreg       <= start_vreg;
                r_idx        <= '0;
                r_slot       <= '0;
                r_line_first <= '0;
                r_line_num   <= '0;
                r_buf        <= '0;
                r_state      <= (start_vl == 12'd0) ? SYNC : LOAD;
            end
        end else if (kill) begin
            r_state <= IDLE;
            r_buf   <= '0;
            r_slot  <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        r_buf  <= r_buf | (MEMDATA_W'(w_elem) << w_shift);
                        r_slot <= w_slot_nx;
                        r_idx  <= w_idx_nx;
                        if (w_line_done) r_state <= EMIT;
                    end
                end
                EMIT: begin
                    r_buf        <= '0;
                    r_slot       <= '0;
                    r_line_first <= r_idx[10:0];
                    r_line_num   <= r_line_num + 5'd1;
                    r_state      <= (r_idx == r_vl) ? SYNC : LOAD;
                end
                SYNC:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // A kill arriving in EMIT/SYNC suppresses that cycle's pulse as well.
    assign w_emit = (r_state == EMIT) && !kill;
    assign w_sync = (r_state == SYNC) && !kill;

    assign mem_ready       = (r_state == LOAD);
    assign busy            = (r_state != IDLE);
    assign load_valid      = w_emit;
    assign load_data       = w_emit ? r_buf : '0;
    assign seq_sb_id       = w_emit ? r_sb_id : '0;
    assign seq_el_count    = w_emit ? 7'(r_slot) : 7'd0;
    assign seq_el_off      = 6'd0;
    assign seq_el_id       = w_emit ? r_line_first : 11'd0;
    assign seq_v_reg       = w_emit ? (r_vreg + r_line_num) : 5'd0;
    assign load_mask       = 64'd0;
    assign load_mask_valid = 1'b0;
    assign sync_end        = w_sync;
    assign sync_sb_id      = w_sync ? r_sb_id : '0;
    assign vstart_vlfof    = 15'd0;

endmodule

// File: tb/tb_ovi_load_packer.sv
// tb/tb_ovi_load_packer.sv - randomized scoreboard bench for ovi_load_packer
module tb_ovi_load_packer;

    localparam int MW = 512;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [SW-1:0] start_sb_id = '0;
    logic [1:0]    start_sew = '0;
    logic [11:0]   start_vl = '0;
    logic [4:0]    start_vreg = '0;
    logic          kill = 1'b0;
    logic          rsp_valid = 1'b0;
    logic [31:0]   rsp_data = '0;
    logic          mem_ready, busy, load_valid, load_mask_valid, sync_end;
    logic [MW-1:0] load_data;
    logic [SW-1:0] seq_sb_id, sync_sb_id;
    logic [6:0]    seq_el_count;
    logic [5:0]    seq_el_off;
    logic [10:0]   seq_el_id;
    logic [4:0]    seq_v_reg;
    logic [63:0]   load_mask;
    logic [14:0]   vstart_vlfof;

    ovi_load_packer #(.MEMDATA_W(MW), .SBID_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .start_sb_id(start_sb_id),
        .start_sew(start_sew), .start_vl(start_vl), .start_vreg(start_vreg),
        .kill(kill), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_ready(mem_ready), .busy(busy), .load_valid(load_valid),
        .load_data(load_data), .seq_sb_id(seq_sb_id), .seq_el_count(seq_el_count),
        .seq_el_off(seq_el_off), .seq_el_id(seq_el_id), .seq_v_reg(seq_v_reg),
        .load_mask(load_mask), .load_mask_valid(load_mask_valid),
        .sync_end(sync_end), .sync_sb_id(sync_sb_id), .vstart_vlfof(vstart_vlfof)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [MW-1:0] data;
        int            cnt;
        int            el_id;
        int            vreg;
        int            sb;
        int            cyc;
    } line_t;

    line_t exp_lines[$];
    int    exp_sync_sb[$];
    int    exp_sync_cyc[$];
    int    n_chk = 0;
    int    n_fail = 0;

    task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every line/sync the DUT presents must match the head of its queue.
    always @(negedge clk) begin
        line_t e;
        if (!rst) begin
            if (load_valid) begin
                if (exp_lines.size() == 0) chk("unexpected_load_valid", 1, 0);
                else begin
                    e = exp_lines.pop_front();
                    chk("load_data", load_data, e.data);
                    chk("el_count", seq_el_count, e.cnt);
                    chk("el_id", seq_el_id, e.el_id);
                    chk("v_reg", seq_v_reg, e.vreg);
                    chk("seq_sb_id", seq_sb_id, e.sb);
                    chk("el_off", seq_el_off, 0);
                    chk("mask", {load_mask_valid, load_mask}, 0);
                    chk("load_cycle", cyc, e.cyc);
                end
            end
            if (sync_end) begin
                if (exp_sync_sb.size() == 0) chk("unexpected_sync_end", 1, 0);
                else begin
                    chk("sync_sb_id", sync_sb_id, exp_sync_sb.pop_front());
                    chk("sync_cycle", cyc, exp_sync_cyc.pop_front());
                    chk("vstart_vlfof", vstart_vlfof, 0);
                end
            end
        end
    end

    task automatic junk_cycle(input bit try_start);
        @(posedge clk); #1;
        kill = 1'b0;
        start = try_start;
        start_sew = 2'd0;
        start_vl = 12'd5;
        rsp_valid = 1'b1;
        rsp_data = $urandom;
    endtask

    // Called and returns at posedge+1 of a cycle where the DUT is IDLE.
    // abort_kind: 0 none, 1 kill, 2 reset, applied when idx == abort_after.
    task automatic run_load(input int sb, input int sew, input int vl, input int vreg,
                            input int gap_pct, input int abort_after, input int abort_kind,
                            input bit kill_start);
        logic [MW-1:0] acc;
        logic [31:0]   val;
        logic [31:0]   msk;
        line_t         ln;
        int            idx, slot, lnum, first, sewb, epl;
        bit            in_emit;
        start = 1'b1; start_sb_id = SW'(sb); start_sew = 2'(sew);
        start_vl = 12'(vl); start_vreg = 5'(vreg);
        kill = kill_start; rsp_valid = 1'b1; rsp_data = $urandom;
        if (sew == 3) begin
            @(posedge clk); #1;
            start = 1'b0; kill = 1'b0; rsp_valid = 1'b0;
            chk("sew3_ignored_busy", busy, 0);
            return;
        end
        if (vl == 0) begin
            exp_sync_sb.push_back(sb);
            exp_sync_cyc.push_back(cyc + 1);
            junk_cycle(1'b1);
            @(posedge clk); #1;
            start = 1'b0; rsp_valid = 1'b0;
            return;
        end
        sewb = 8 << sew; epl = MW / sewb;
        msk = (sewb == 32) ? 32'hffff_ffff : ((32'd1 << sewb) - 32'd1);
        acc = '0; idx = 0; slot = 0; lnum = 0; first = 0; in_emit = 1'b0;
        while (idx < vl) begin
            @(posedge clk); #1;
            start = 1'b0; kill = 1'b0; rsp_valid = 1'b0;
            if ($urandom % 16 == 0) begin
                start = 1'b1; start_sew = 2'($urandom % 3);
                start_vl = 12'(1 + $urandom % 50); start_sb_id = SW'($urandom);
            end
            if (abort_kind != 0 && idx == abort_after) begin
                if (in_emit) ln = exp_lines.pop_back();
                rsp_valid = 1'b1; rsp_data = $urandom;
                if (abort_kind == 1) begin
                    kill = 1'b1;
                    @(posedge clk); #1;
                    kill = 1'b0; start = 1'b0; rsp_valid = 1'b0;
                    chk("busy_after_kill", busy, 0);
                end else begin
                    #2 rst = 1'b1;
                    #1;
                    chk("rst_busy", busy, 0);
                    chk("rst_mem_ready", mem_ready, 0);
                    chk("rst_load_valid", load_valid, 0);
                    chk("rst_sync_end", sync_end, 0);
                    chk("rst_load_data", load_data, 0);
                    @(posedge clk); #1;
                    rst = 1'b0; start = 1'b0; rsp_valid = 1'b0;
                end
                return;
            end
            if (in_emit) begin
                in_emit = 1'b0;
                rsp_valid = 1'b1; rsp_data = $urandom;
                continue;
            end
            if (($urandom % 100) >= gap_pct) begin
                rsp_valid = 1'b1; rsp_data = $urandom;
                val = rsp_data & msk;
                acc = acc | (MW'(val) << (slot * sewb));
                slot++; idx++;
                if (slot == epl || idx == vl) begin
                    ln.data = acc; ln.cnt = slot; ln.el_id = first;
                    ln.vreg = (vreg + lnum) % 32; ln.sb = sb; ln.cyc = cyc + 1;
                    exp_lines.push_back(ln);
                    acc = '0; first = idx; slot = 0; lnum++; in_emit = 1'b1;
                    if (idx == vl) begin
                        exp_sync_sb.push_back(sb);
                        exp_sync_cyc.push_back(cyc + 2);
                    end
                end
            end else begin
                rsp_data = $urandom;
            end
        end
        junk_cycle(1'b1);
        junk_cycle(1'b1);
        @(posedge clk); #1;
        start = 1'b0; rsp_valid = 1'b0;
    endtask

    initial begin
        int s, v, ab, kind;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_mem_ready", mem_ready, 0);
        chk("reset_load_valid", load_valid, 0);
        chk("reset_sync_end", sync_end, 0);
        chk("reset_load_data", load_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_load(3, 2, 16, 4, 0, -1, 0, 1'b0);
        run_load(9, 0, 70, 31, 0, -1, 0, 1'b0);
        run_load(7, 0, 0, 0, 0, -1, 0, 1'b0);
        run_load(12, 1, 40, 2, 0, 35, 1, 1'b0);
        run_load(13, 1, 40, 6, 20, 32, 1, 1'b0);
        run_load(14, 1, 20, 8, 30, -1, 0, 1'b1);
        run_load(15, 3, 20, 8, 0, -1, 0, 1'b0);
        run_load(16, 2, 20, 9, 10, 5, 2, 1'b0);
        for (int i = 0; i < 25; i++) begin
            s = $urandom % 3;
            v = ($urandom % 8 == 0) ? 0 : 1 + $urandom % 200;
            ab = -1; kind = 0;
            if (v > 0 && $urandom % 6 == 0) begin
                ab = $urandom % v;
                kind = 1 + $urandom % 2;
            end
            run_load($urandom % 32, s, v, $urandom % 32, $urandom % 60, ab, kind, 1'($urandom));
        end
        run_load(30, 0, 2048, 30, 0, -1, 0, 1'b0);
        repeat (5) junk_cycle(1'b0);
        @(posedge clk); #1;
        rsp_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("lines_pending", exp_lines.size(), 0);
        chk("syncs_pending", exp_sync_sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
